// File: rtl/multu_hilo_if.sv
// Core-side bus for the iterative multiplier: MULTU issue, Hi/Lo read port and status.
interface multu_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, src_a, src_b, rd_sel,
    input  rd_data, busy, done, hi, lo
  );

  modport slave (
    input  start, src_a, src_b, rd_sel,
    output rd_data, busy, done, hi, lo
  );
endinterface

// File: rtl/multu_hilo.sv
// Iterative shift-add unsigned WIDTHxWIDTH multiplier with the architectural Hi/Lo pair.
// One product bit retires per cycle; Hi/Lo update only on the final step.
module multu_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  multu_hilo_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [PW-1:0]    r_p;
  logic [PW-1:0]    w_p_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_p_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_p     <= w_p_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // One shift-add step: conditional add into the upper half, carry kept, then shift right.
  always_comb begin
    w_sum = {1'b0, r_p[PW-1:WIDTH]};
    if (r_p[0]) begin
      w_sum = {1'b0, r_p[PW-1:WIDTH]} + {1'b0, r_mcand};
    end
    w_p_shift = {w_sum, r_p[WIDTH-1:1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_p_nxt     = r_p;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mcand_nxt = bus.src_a;
          w_p_nxt     = {WIDTH'(0), bus.src_b};
          w_cnt_nxt   = '0;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_p_nxt = w_p_shift;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_hi_nxt    = w_p_shift[PW-1:WIDTH];
          w_lo_nxt    = w_p_shift[WIDTH-1:0];
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status decodes straight from the state register; the read mux is combinational by design.
  assign bus.busy    = (r_state == S_BUSY);
  assign bus.done    = (r_state == S_DONE);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_multu_hilo.sv
// Randomised and directed checks of multu_hilo against a plain-arithmetic product model.
module tb_multu_hilo;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(W)) u_if ();

  multu_hilo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MULTU and follow it cycle by cycle; inj > 0 pulses an illegal start in that BUSY cycle.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.src_a = a;
    u_if.src_b = b;
    u_if.rd_sel = 1'b0;
    tick();
    u_if.start = 1'b0;
    u_if.src_a = $urandom;
    u_if.src_b = $urandom;
    chk("busy_first", 64'(u_if.busy), 64'd1);
    for (int i = 1; i < int'(W); i++) begin
      if (i == inj) begin
        u_if.start = 1'b1;
        u_if.src_a = 100;
        u_if.src_b = 100;
      end else begin
        u_if.start = 1'b0;
      end
      tick();
      chk("busy_hold", 64'(u_if.busy), 64'd1);
      chk("done_early", 64'(u_if.done), 64'd0);
      chk("stale_lo", 64'(u_if.rd_data), 64'(exp_lo));
    end
    u_if.start = 1'b0;
    tick();
    exp_hi = prod[63:32];
    exp_lo = prod[31:0];
    chk("done_pulse", 64'(u_if.done), 64'd1);
    chk("busy_off", 64'(u_if.busy), 64'd0);
    chk("hi", 64'(u_if.hi), 64'(exp_hi));
    chk("lo", 64'(u_if.lo), 64'(exp_lo));
    chk("mflo", 64'(u_if.rd_data), 64'(exp_lo));
    u_if.rd_sel = 1'b1;
    #1;
    chk("mfhi", 64'(u_if.rd_data), 64'(exp_hi));
    u_if.rd_sel = 1'b0;
    tick();
    chk("done_once", 64'(u_if.done), 64'd0);
    chk("idle_busy", 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.src_a = '0;
    u_if.src_b = '0;
    u_if.rd_sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(u_if.busy), 64'd0);
    chk("rst_done", 64'(u_if.done), 64'd0);
    chk("rst_hi", 64'(u_if.hi), 64'd0);
    chk("rst_lo", 64'(u_if.lo), 64'd0);
    chk("rst_rd", 64'(u_if.rd_data), 64'd0);

    run_mul(32'd3, 32'd5, 0);
    run_mul(32'd2, 32'd2, 0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("max_hi_const", 64'(u_if.hi), 64'hFFFF_FFFE);
    run_mul(32'h8000_0000, 32'd2, 0);
    run_mul(32'h1234_5678, 32'd0, 0);
    run_mul(32'd7, 32'd9, 10);
    chk("inj_lo_const", 64'(u_if.lo), 64'd63);

    // Reset during BUSY aborts the operation and clears Hi/Lo.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.src_a = 32'hDEAD_BEEF;
    u_if.src_b = 32'h10;
    tick();
    u_if.start = 1'b0;
    repeat (14) tick();
    chk("pre_rst_busy", 64'(u_if.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort_busy", 64'(u_if.busy), 64'd0);
    chk("abort_hi", 64'(u_if.hi), 64'd0);
    chk("abort_lo", 64'(u_if.lo), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (u_if.done || u_if.busy) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    u_if.start = 1'b1;
    u_if.src_a = 32'd11;
    u_if.src_b = 32'd13;
    tick();
    rst = 1'b0;
    u_if.start = 1'b0;
    tick();
    chk("rst_start_busy", 64'(u_if.busy), 64'd0);
    chk("rst_start_lo", 64'(u_if.lo), 64'd0);

    for (int k = 0; k < 20; k++) begin
      run_mul($urandom, $urandom, (k % 4 == 0) ? int'($urandom_range(1, W - 1)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
